knn_distance_unit: RTL and testbench

- Sequential, parametrised successor to the KNN distance calculator. Computes the distance between one training sample and one input sample, each M*N features of W bits.
- Processes LANES features per clock.
- Metric is selectable per request: Manhattan or squared Euclidean.
- Uses valid/ready handshakes on both sides so the sorter/voter stage downstream can apply backpressure. The training label passes through alongside the result.

---
 rtl/knn_pkg.sv | 19 +
 rtl/knn_lane_term.sv | 23 ++
 rtl/knn_distance_unit.sv | 162 ++++++++++++++++
 tb/tb_knn_distance_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the KNN distance datapath and its downstream sorter.
package knn_pkg;

  localparam logic METRIC_MANHATTAN = 1'b0;
  localparam logic METRIC_SQEUCLID  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } knn_state_e;

  // Each term is at most 2W bits, and f of them need clog2(f) more bits to
  // add up without overflow.
  function automatic int knn_dist_w(input int w, input int f);
    return 2 * w + $clog2(f);
  endfunction

endpackage

// File: rtl/knn_lane_term.sv
// One lane: unsigned |a-b|, or its square, zero-extended to 2W bits.
module knn_lane_term
  import knn_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           metric_i,
  output logic [2*W-1:0] term_o
);

  logic [W-1:0]   diff;
  logic [2*W-1:0] diff_x;

  // The larger operand minus the smaller one, so no sign bit is needed.
  always_comb begin
    diff   = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    diff_x = {{W{1'b0}}, diff};
    term_o = (metric_i == METRIC_SQEUCLID) ? (diff_x * diff_x) : diff_x;
  end

endmodule

// File: rtl/knn_distance_unit.sv
// Sequential KNN distance: LANES features per cycle, with valid/ready on both sides.
module knn_distance_unit
  import knn_pkg::*;
#(
  parameter  int M     = 2,
  parameter  int N     = 3,
  parameter  int W     = 32,
  parameter  int LW    = 32,
  parameter  int LANES = 1,
  localparam int F     = M * N,
  localparam int DW    = knn_dist_w(W, M * N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            metric,
  input  logic [F*W-1:0]  training_data,
  input  logic [LW-1:0]   training_data_type,
  input  logic [F*W-1:0]  input_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   distance,
  output logic [LW-1:0]   data_type,
  output logic            done
);

  localparam int G  = F / LANES;
  localparam int IW = (G > 1) ? $clog2(G) : 1;

  if (F % LANES != 0) begin : g_bad_lanes
    $error("knn_distance_unit: F=%0d is not divisible by LANES=%0d", F, LANES);
  end

  knn_state_e              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           acc_q, acc_d;
  logic [DW-1:0]           dist_q, dist_d;
  logic [LW-1:0]           type_q, type_d;
  logic [LW-1:0]           lbl_q, lbl_d;
  logic                    met_q, met_d;
  logic                    done_q, done_d;
  logic [F-1:0][W-1:0]     trn_q, trn_d;
  logic [F-1:0][W-1:0]     inp_q, inp_d;
  logic [LANES-1:0][2*W-1:0] term;
  logic [DW-1:0]           lane_sum;
  logic                    accept;
  logic                    last;

  // Feature vectors shift down by one lane group per ACCUM cycle, so the
  // lanes always read the bottom LANES features.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    knn_lane_term #(.W(W)) u_term (
      .a_i      (trn_q[l]),
      .b_i      (inp_q[l]),
      .metric_i (met_q),
      .term_o   (term[l])
    );
  end

  // Adder tree across the lanes, zero-extended to the full distance width.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + DW'(term[l]);
  end

  assign accept = in_valid && in_ready;
  assign last   = (idx_q == IW'(G - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_ACCUM;
      ST_ACCUM: if (last)      state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_HOLD);
  end

  // Datapath next state: capture on accept, accumulate, load result on the
  // last group, pulse done on the output handshake. clear freezes it.
  always_comb begin
    trn_d  = trn_q;
    inp_d  = inp_q;
    met_d  = met_q;
    lbl_d  = lbl_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    dist_d = dist_q;
    type_d = type_q;
    done_d = 1'b0;
    if (!clear) begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          trn_d = training_data;
          inp_d = input_data;
          met_d = metric;
          lbl_d = training_data_type;
          acc_d = '0;
          idx_d = '0;
        end
        ST_ACCUM: begin
          acc_d = acc_q + lane_sum;
          idx_d = idx_q + 1'b1;
          trn_d = trn_q >> (LANES * W);
          inp_d = inp_q >> (LANES * W);
          if (last) begin
            dist_d = acc_q + lane_sum;
            type_d = lbl_q;
          end
        end
        ST_HOLD: done_d = out_ready;
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trn_q  <= '0;
      inp_q  <= '0;
      met_q  <= METRIC_MANHATTAN;
      lbl_q  <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      dist_q <= '0;
      type_q <= '0;
      done_q <= 1'b0;
    end else begin
      trn_q  <= trn_d;
      inp_q  <= inp_d;
      met_q  <= met_d;
      lbl_q  <= lbl_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      dist_q <= dist_d;
      type_q <= type_d;
      done_q <= done_d;
    end
  end

  assign distance  = dist_q;
  assign data_type = type_q;
  assign done      = done_q;

endmodule

// File: tb/tb_knn_distance_unit.sv
// Directed bench for knn_distance_unit: LANES=1 main instance plus LANES=2/3 instances.
module tb_knn_distance_unit;
  import knn_pkg::*;

  localparam int W  = 32;
  localparam int F  = 6;
  localparam int LW = 32;
  localparam int DW = knn_dist_w(W, F);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic metric = 1'b0;
  logic out_ready = 1'b1;
  logic [F*W-1:0] trn = '0;
  logic [F*W-1:0] inp = '0;
  logic [LW-1:0]  lbl = '0;

  logic in_ready, out_valid, done;
  logic [DW-1:0] distance;
  logic [LW-1:0] data_type;

  logic iv2 = 1'b0, iv3 = 1'b0;
  logic ir2, ov2, dn2, ir3, ov3, dn3;
  logic [DW-1:0] d2, d3;
  logic [LW-1:0] t2, t3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  knn_distance_unit dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .metric(metric), .training_data(trn), .training_data_type(lbl), .input_data(inp),
    .out_valid(out_valid), .out_ready(out_ready), .distance(distance),
    .data_type(data_type), .done(done)
  );

  knn_distance_unit #(.LANES(2)) dut2 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(iv2), .in_ready(ir2),
    .metric(metric), .training_data(trn), .training_data_type(lbl), .input_data(inp),
    .out_valid(ov2), .out_ready(1'b1), .distance(d2), .data_type(t2), .done(dn2)
  );

  knn_distance_unit #(.LANES(3)) dut3 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(iv3), .in_ready(ir3),
    .metric(metric), .training_data(trn), .training_data_type(lbl), .input_data(inp),
    .out_valid(ov3), .out_ready(1'b1), .distance(d3), .data_type(t3), .done(dn3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // worst=0: training {1..6}, input {6..1}; worst=1: training 0, input all ones.
  task automatic set_vec(input bit worst);
    for (int i = 0; i < F; i++) begin
      trn[i*W +: W] = worst ? 32'd0 : 32'(i + 1);
      inp[i*W +: W] = worst ? 32'hFFFF_FFFF : 32'(6 - i);
    end
  endtask

  // Inputs are don't-care once accepted; scramble them to prove they were registered.
  task automatic scramble();
    trn    = ~trn;
    inp    = ~inp;
    metric = ~metric;
    lbl    = ~lbl;
  endtask

  // Called at a negedge; the request is accepted on the following posedge.
  task automatic start(input bit worst, input logic met, input logic [LW-1:0] label);
    set_vec(worst);
    metric   = met;
    lbl      = label;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    chk("busy_after_accept", in_ready, 1'b0);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_full(input string tag, input bit worst, input logic met,
                          input logic [LW-1:0] label, input logic [DW-1:0] exp);
    int n;
    @(negedge clk);
    start(worst, met, label);
    wait_out(n);
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_dist"}, distance, exp);
    chk({tag, "_type"}, data_type, label);
    chk({tag, "_done_early"}, done, 1'b0);
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_ov_drop"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 1'b0);
  endtask

  task automatic run_lane(input int sel, input logic met, input logic [DW-1:0] exp, input int lat);
    int n;
    @(negedge clk);
    set_vec(1'b0);
    metric = met;
    lbl    = 32'd2;
    if (sel == 2) iv2 = 1'b1; else iv3 = 1'b1;
    @(negedge clk);
    iv2 = 1'b0;
    iv3 = 1'b0;
    scramble();
    n = 0;
    while (!((sel == 2) ? ov2 : ov3) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("lanes%0d_m%0d_latency", sel, met), n, lat);
    chk($sformatf("lanes%0d_m%0d_dist", sel, met), (sel == 2) ? d2 : d3, exp);
    chk($sformatf("lanes%0d_m%0d_type", sel, met), (sel == 2) ? t2 : t3, 32'd2);
    @(negedge clk);
    chk($sformatf("lanes%0d_m%0d_done", sel, met), (sel == 2) ? dn2 : dn3, 1'b1);
    chk($sformatf("lanes%0d_m%0d_ready", sel, met), (sel == 2) ? ir2 : ir3, 1'b1);
  endtask

  initial begin
    int n;
    int seen;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_dist", distance, 0);
    chk("rst_type", data_type, 0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", in_ready, 1'b1);

    // Main function, LANES=1
    run_full("man", 1'b0, 1'b0, 32'd2, 67'd18);
    run_full("sq", 1'b0, 1'b1, 32'd3, 67'd70);
    run_full("worst_sq", 1'b1, 1'b1, 32'd4, 67'h5_FFFF_FFF4_0000_0006);
    run_full("worst_man", 1'b1, 1'b0, 32'd5, 67'd25769803770);

    // Wider lane counts
    run_lane(2, 1'b0, 67'd18, 3);
    run_lane(2, 1'b1, 67'd70, 3);
    run_lane(3, 1'b0, 67'd18, 2);
    run_lane(3, 1'b1, 67'd70, 2);

    // Backpressure: hold for 5 cycles, with an ignored second request
    out_ready = 1'b0;
    @(negedge clk);
    start(1'b0, 1'b0, 32'd2);
    wait_out(n);
    chk("bp_latency", n, 6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_ov_%0d", c), out_valid, 1'b1);
      chk($sformatf("bp_dist_%0d", c), distance, 67'd18);
      chk($sformatf("bp_type_%0d", c), data_type, 32'd2);
      chk($sformatf("bp_ready_%0d", c), in_ready, 1'b0);
      chk($sformatf("bp_done_%0d", c), done, 1'b0);
      if (c == 1) begin
        set_vec(1'b1);
        lbl = 32'd9;
        in_valid = 1'b1;
      end
      if (c == 3) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", done, 1'b1);
    chk("bp_ov_drop", out_valid, 1'b0);
    chk("bp_ready_back", in_ready, 1'b1);
    chk("bp_dist_kept", distance, 67'd18);
    // Next request one cycle after done
    start(1'b0, 1'b1, 32'd5);
    wait_out(n);
    chk("bp_next_latency", n, 6);
    chk("bp_next_dist", distance, 67'd70);
    chk("bp_next_type", data_type, 32'd5);
    @(negedge clk);
    chk("bp_next_done", done, 1'b1);

    // clear together with in_valid discards the request
    @(negedge clk);
    set_vec(1'b0);
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    chk("clr_acc_ready", in_ready, 1'b1);
    repeat (7) @(negedge clk);
    chk("clr_acc_no_ov", out_valid, 1'b0);
    chk("clr_acc_dist", distance, 67'd70);

    // Abort on the 3rd ACCUM cycle
    @(negedge clk);
    start(1'b0, 1'b1, 32'd7);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_ov", out_valid, 1'b0);
    chk("abort_dist_kept", distance, 67'd70);
    chk("abort_type_kept", data_type, 32'd5);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || done) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_full("after_abort", 1'b0, 1'b0, 32'd2, 67'd18);

    // Async reset between edges mid-ACCUM
    @(negedge clk);
    start(1'b0, 1'b1, 32'd6);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_dist", distance, 0);
    chk("arst_type", data_type, 0);
    chk("arst_ov", out_valid, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_ready", in_ready, 1'b1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || done) seen++;
    end
    chk("arst_no_result", seen, 0);
    run_full("after_arst", 1'b0, 1'b0, 32'd2, 67'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
